// File: rtl/sdram_host_responder.sv
// Block-RAM stand-in for the sdramCntl host handshake (rd/wr/done).
// Models access latency and periodic refresh stalls.
module sdram_host_responder #(
    parameter int ADDR_BITS   = 12,
    parameter int RD_LAT      = 3,
    parameter int WR_LAT      = 2,
    parameter int RFSH_PERIOD = 390,
    parameter int RFSH_CYCLES = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rd,
    input  logic        wr,
    input  logic [23:0] hAddr,
    input  logic [15:0] hDIn,
    output logic        done,
    output logic [15:0] hDOut,
    output logic        rfsh_active
);

    localparam int DEPTH   = 1 << ADDR_BITS;
    localparam int LMAX    = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
    localparam int CMAX    = (LMAX > RFSH_CYCLES) ? LMAX : RFSH_CYCLES;
    localparam int CW      = $clog2(CMAX + 1);
    localparam int RW      = $clog2(RFSH_PERIOD + 1);
    localparam bit RFSH_EN = (RFSH_CYCLES != 0);

    typedef enum logic [1:0] {IDLE, BUSY, RFSH} state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d, rd_addr;
    logic [15:0]           data_q, data_d, hdout_d, rdata_q;
    logic                  wr_op_q, wr_op_d;
    logic                  done_d, rfsh_d;
    logic                  pend_q, pend_clr;
    logic                  accept, commit, rfsh_wrap;
    logic [RW-1:0]         rcnt_q;
    logic [15:0]           mem [DEPTH];
    logic                  unused_haddr;

    assign unused_haddr = ^hAddr[23:ADDR_BITS];
    assign rfsh_wrap    = (rcnt_q == RW'(RFSH_PERIOD - 1));
    // Steer the RAM read port at the new address on the acceptance edge
    assign rd_addr      = accept ? hAddr[ADDR_BITS-1:0] : addr_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        data_d   = data_q;
        wr_op_d  = wr_op_q;
        hdout_d  = hDOut;
        rfsh_d   = rfsh_active;
        done_d   = 1'b0;
        pend_clr = 1'b0;
        accept   = 1'b0;
        commit   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pend_q) begin
                    state_d  = RFSH;
                    rfsh_d   = 1'b1;
                    cnt_d    = CW'(RFSH_CYCLES - 1);
                    pend_clr = 1'b1;
                end else if (!done && (rd || wr)) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                    addr_d  = hAddr[ADDR_BITS-1:0];
                    data_d  = hDIn;
                    wr_op_d = !rd;
                    cnt_d   = rd ? CW'(RD_LAT - 1) : CW'(WR_LAT - 1);
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    if (wr_op_q) commit = 1'b1;
                    else         hdout_d = rdata_q;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RFSH: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    rfsh_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            wr_op_q     <= 1'b0;
            done        <= 1'b0;
            hDOut       <= 16'h0000;
            rfsh_active <= 1'b0;
            rcnt_q      <= '0;
            pend_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            wr_op_q     <= wr_op_d;
            done        <= done_d;
            hDOut       <= hdout_d;
            rfsh_active <= rfsh_d;
            rcnt_q      <= rfsh_wrap ? '0 : rcnt_q + RW'(1);
            // A fresh wrap outranks the clear so no period is silently dropped
            if (RFSH_EN && rfsh_wrap) pend_q <= 1'b1;
            else if (pend_clr)        pend_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) mem[addr_q] <= data_q;
        rdata_q <= mem[rd_addr];
    end

endmodule

// File: tb/tb_sdram_host_responder.sv
// Scoreboard bench for sdram_host_responder: directed cases plus
// randomized traffic against an array model of the halfword store.
module tb_sdram_host_responder;

    localparam int AB  = 12;
    localparam int RDL = 3;
    localparam int WRL = 2;
    localparam int RP  = 390;
    localparam int RC  = 8;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [23:0] hAddr = '0;
    logic [15:0] hDIn = '0;
    logic        done;
    logic [15:0] hDOut;
    logic        rfsh_active;

    int checks = 0;
    int errors = 0;
    int cyc;

    typedef struct {
        bit          is_rd;
        logic [15:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] mm [0:(1<<AB)-1];
    logic [15:0] exp_hd;
    int          run;

    sdram_host_responder #(
        .ADDR_BITS(AB), .RD_LAT(RDL), .WR_LAT(WRL),
        .RFSH_PERIOD(RP), .RFSH_CYCLES(RC)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rd(rd), .wr(wr),
        .hAddr(hAddr), .hDIn(hDIn), .done(done),
        .hDOut(hDOut), .rfsh_active(rfsh_active)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge reset_n)
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: pops expectations on done, checks hDOut hold and refresh length
    initial begin
        exp_t e;
        exp_hd = 16'h0000;
        run = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                sbq.delete();
                exp_hd = 16'h0000;
                run = 0;
                checks++;
                if (done !== 1'b0 || hDOut !== 16'h0 || rfsh_active !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_outputs: done=%b hDOut=%h rfsh=%b required 0/0000/0",
                             done, hDOut, rfsh_active);
                end
            end else begin
                if (done === 1'b1) begin
                    checks++;
                    if (sbq.size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_done at cyc %0d: no outstanding request", cyc);
                    end else begin
                        e = sbq.pop_front();
                        if (e.is_rd) exp_hd = e.data;
                    end
                end
                checks++;
                if (hDOut !== exp_hd) begin
                    errors++;
                    $display("FAIL hdout at cyc %0d: got %h required %h", cyc, hDOut, exp_hd);
                end
                if (rfsh_active === 1'b1) begin
                    run++;
                end else if (run != 0) begin
                    checks++;
                    if (run != RC) begin
                        errors++;
                        $display("FAIL rfsh_len: got %0d cycles required %0d", run, RC);
                    end
                    run = 0;
                end
            end
        end
    end

    // Called on a negedge; returns on the negedge after the done cycle
    task automatic do_op(input bit r, input bit w, input logic [23:0] a,
                         input logic [15:0] d, output logic [15:0] q,
                         output int lat);
        exp_t e;
        int   nom;
        bit   saw;
        rd    = r;
        wr    = w;
        hAddr = a;
        hDIn  = d;
        e.is_rd = r;
        e.data  = r ? mm[a[AB-1:0]] : 16'h0;
        sbq.push_back(e);
        if (w && !r) mm[a[AB-1:0]] = d;
        nom = (r ? RDL : WRL) + 1;
        saw = (rfsh_active === 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (rfsh_active === 1'b1) saw = 1'b1;
        end while (done !== 1'b1 && lat < 200);
        rd = 1'b0;
        wr = 1'b0;
        q  = hDOut;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL timeout: no done within %0d cycles for addr %h", lat, a);
        end else if (!saw && lat != nom) begin
            errors++;
            $display("FAIL latency: got %0d required %0d (rd=%b wr=%b)", lat, nom, r, w);
        end else if (saw && (lat <= nom || lat > nom + RC + 1)) begin
            errors++;
            $display("FAIL latency_rfsh: got %0d required %0d..%0d", lat, nom + 1, nom + RC + 1);
        end
        @(negedge clk);
    endtask

    task automatic expect16(input string name, input logic [15:0] got,
                            input logic [15:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, got, req);
        end
    endtask

    initial begin
        logic [15:0] q, q1, q2, old;
        logic [AB-1:0] pool [16];
        int lat;
        int op;

        repeat (3) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);

        // Write then read back
        do_op(1'b0, 1'b1, 24'd5, 16'hBEEF, q, lat);
        do_op(1'b1, 1'b0, 24'd5, 16'h0, q, lat);
        expect16("read_beef", q, 16'hBEEF);

        // Back-to-back word access
        do_op(1'b0, 1'b1, 24'd8, 16'h1234, q, lat);
        do_op(1'b0, 1'b1, 24'd9, 16'h5678, q, lat);
        do_op(1'b1, 1'b0, 24'd8, 16'h0, q1, lat);
        do_op(1'b1, 1'b0, 24'd9, 16'h0, q2, lat);
        checks++;
        if ({q1, q2} !== 32'h12345678) begin
            errors++;
            $display("FAIL word: got %h required 12345678", {q1, q2});
        end

        // Upper address bits alias
        do_op(1'b0, 1'b1, 24'h001003, 16'hA5C3, q, lat);
        do_op(1'b1, 1'b0, 24'h000003, 16'h0, q, lat);
        expect16("alias", q, 16'hA5C3);

        // rd wins over wr
        do_op(1'b0, 1'b1, 24'd20, 16'h1357, q, lat);
        do_op(1'b1, 1'b1, 24'd20, 16'h0F0F, q, lat);
        expect16("rdwr_read", q, 16'h1357);
        do_op(1'b1, 1'b0, 24'd20, 16'h0, q, lat);
        expect16("rdwr_nowrite", q, 16'h1357);

        // Request on the edge where the first refresh is pending
        while (cyc < RP) @(negedge clk);
        checks++;
        if (rfsh_active !== 1'b0) begin
            errors++;
            $display("FAIL rfsh_early: got %b required 0", rfsh_active);
        end
        do_op(1'b1, 1'b0, 24'd5, 16'h0, q, lat);
        checks++;
        if (lat != RDL + 1 + RC + 1) begin
            errors++;
            $display("FAIL rfsh_collision: latency %0d required %0d", lat, RDL + RC + 2);
        end
        expect16("rfsh_data", q, 16'hBEEF);

        // Randomized traffic over a small aliased address pool
        for (int i = 0; i < 16; i++) begin
            pool[i] = AB'($urandom);
            do_op(1'b0, 1'b1, {12'($urandom), pool[i]}, 16'($urandom), q, lat);
        end
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 3);
            do_op(op == 0 || op == 3, op >= 1,
                  {12'($urandom), pool[$urandom_range(0, 15)]},
                  16'($urandom), q, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Reset one cycle before the write's done edge
        old   = mm[5];
        rd    = 1'b0;
        wr    = 1'b1;
        hAddr = 24'd5;
        hDIn  = ~old;
        @(negedge clk);
        @(negedge clk);
        #2 reset_n = 1'b0;
        wr = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        expect16("post_reset_hdout", hDOut, 16'h0000);
        do_op(1'b1, 1'b0, 24'd5, 16'h0, q, lat);
        expect16("reset_nocommit", q, old);

        repeat (5) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL leftover: %0d outstanding required 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
